// File: rtl/interface_tx.sv
// Result buffer between the ALU and the UART transmitter: a small circular FIFO
// drained one byte at a time through a tx_start / tx_done_tick handshake.
module interface_tx #(
  parameter int unsigned DBIT   = 8,
  parameter int unsigned FIFO_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr,
  input  logic [DBIT-1:0] w_data,
  input  logic            tx_done_tick,
  output logic            tx_start,
  output logic [DBIT-1:0] tx_data,
  output logic            tx_full,
  output logic            tx_empty,
  output logic            tx_busy,
  output logic            overflow
);

  localparam int unsigned Depth = 2 ** FIFO_W;
  localparam logic [FIFO_W:0] FullCnt = (FIFO_W + 1)'(Depth);
  localparam logic [FIFO_W:0] CntOne  = (FIFO_W + 1)'(1);
  localparam logic [FIFO_W-1:0] PtrOne = FIFO_W'(1);

  typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

  state_e            state_q, state_d;
  logic [FIFO_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_W:0]   count_q, count_d;
  logic              tx_start_q, tx_start_d;
  logic [DBIT-1:0]   tx_data_q, tx_data_d;
  logic              overflow_q, overflow_d;
  logic [DBIT-1:0]   mem [Depth];

  logic full, empty, pop, push, drop;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign push  = wr & (~full | pop);
  assign drop  = wr & full & ~pop;

  // FIFO bookkeeping
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop)  rd_ptr_d = rd_ptr_q + PtrOne;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty) state_d = StStart;
      StStart: state_d = StWait;
      StWait:  if (tx_done_tick) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs (registered) and pop strobe
  always_comb begin
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (state_q == StIdle && !empty) begin
      pop        = 1'b1;
      tx_start_d = 1'b1;
      tx_data_d  = mem[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= w_data;
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign tx_full  = full;
  assign tx_empty = empty;
  assign tx_busy  = (state_q != StIdle);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_interface_tx.sv
// Bench for interface_tx: a per-cycle vector table for the single-byte and
// ignored-tick cases, then hand-written sequences for queueing, overflow and reset.
module tb_interface_tx;

  logic       clk = 1'b0;
  logic       reset, wr, tx_done_tick;
  logic [7:0] w_data;
  logic       tx_start, tx_full, tx_empty, tx_busy, overflow;
  logic [7:0] tx_data;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sent_q[$];

  always #5 clk = ~clk;

  interface_tx #(.DBIT(8), .FIFO_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .tx_busy      (tx_busy),
    .overflow     (overflow)
  );

  // Log every byte handed to the transmitter.
  always @(negedge clk) if (tx_start) sent_q.push_back(tx_data);

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       done;
    logic       e_start;
    logic [7:0] e_data;
    logic       e_full;
    logic       e_empty;
    logic       e_busy;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic w, input logic [7:0] d, input logic dn);
    reset = r; wr = w; w_data = d; tx_done_tick = dn;
    @(posedge clk);
    #1;
    reset = 1'b0; wr = 1'b0; w_data = 8'h00; tx_done_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Acknowledge n frames: wait for busy, hold for gap cycles, then pulse done.
  task automatic drain(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!tx_busy && t < 10) begin
        idle(1);
        t++;
      end
      check("drain_busy_timeout", 32'(tx_busy), 32'd1);
      idle(gap);
      cyc(1'b0, 1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic check_sent(input string name, input int base, input int n, input logic [7:0] first);
    check({name, "_count"}, 32'(sent_q.size() - base), 32'(n));
    for (int i = 0; i < n; i++) begin
      logic [31:0] got;
      got = (base + i < sent_q.size()) ? 32'(sent_q[base + i]) : 32'hFFFF;
      check({name, "_order"}, got, 32'(first + 8'(i)));
    end
  endtask

  initial begin
    int base;
    reset = 1'b1; wr = 1'b0; w_data = 8'h00; tx_done_tick = 1'b0;

    //          rst  wr   wd     done start data   full empty busy ovf
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].done);
      check($sformatf("v%0d_start", i), 32'(tx_start), 32'(vecs[i].e_start));
      check($sformatf("v%0d_data", i),  32'(tx_data),  32'(vecs[i].e_data));
      check($sformatf("v%0d_full", i),  32'(tx_full),  32'(vecs[i].e_full));
      check($sformatf("v%0d_empty", i), 32'(tx_empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_busy", i),  32'(tx_busy),  32'(vecs[i].e_busy));
      check($sformatf("v%0d_ovf", i),   32'(overflow), 32'(vecs[i].e_ovf));
    end

    // Four results back-to-back, slow transmitter.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    base = sent_q.size();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(i + 1), 1'b0);
    drain(4, 20);
    idle(5);
    check_sent("b2b", base, 4, 8'h01);
    check("b2b_empty", 32'(tx_empty), 32'd1);
    check("b2b_busy", 32'(tx_busy), 32'd0);

    // Fill to capacity while one is in flight, then overflow.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    base = sent_q.size();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h10 + 8'(i), 1'b0);
    check("fill_full", 32'(tx_full), 32'd1);
    check("fill_ovf", 32'(overflow), 32'd0);
    check("fill_inflight", 32'(tx_data), 32'h10);
    cyc(1'b0, 1'b1, 8'h15, 1'b0);
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_full", 32'(tx_full), 32'd1);
    drain(5, 2);
    idle(5);
    check_sent("ovf", base, 5, 8'h10);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check("ovf_empty", 32'(tx_empty), 32'd1);

    // Write to a full FIFO in the same cycle the FSM pops.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    base = sent_q.size();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h20 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b1, 8'h25, 1'b0);
    check("coinc_full", 32'(tx_full), 32'd1);
    check("coinc_ovf", 32'(overflow), 32'd0);
    check("coinc_start", 32'(tx_start), 32'd1);
    check("coinc_data", 32'(tx_data), 32'h21);
    drain(5, 2);
    idle(5);
    check_sent("coinc", base, 6, 8'h20);
    check("coinc_ovf_end", 32'(overflow), 32'd0);

    // Reset mid-frame with three queued.
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
    check("rst_pre_busy", 32'(tx_busy), 32'd1);
    check("rst_pre_empty", 32'(tx_empty), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_empty", 32'(tx_empty), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_start", 32'(tx_start), 32'd0);
    base = sent_q.size();
    idle(3);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    idle(6);
    check("rst_no_start", 32'(sent_q.size() - base), 32'd0);
    check("rst_idle", 32'(tx_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
